// File: rtl/array_pkg.sv
// Shared constants and types for the array packer.
// Two arrays of ARR_N elements, each ARR_W bits wide, are assembled back to back.
package array_pkg;

    localparam int ARR_N = 10;
    localparam int ARR_W = 8;
    localparam int CNT_W = $clog2(ARR_N);

    typedef enum logic [1:0] {
        FILL_A = 2'd0,
        FILL_B = 2'd1,
        HOLD   = 2'd2
    } state_t;

endpackage

// File: rtl/elem_shift_reg.sv
// Element-wide shift register: new elements enter at the LSB end and older ones
// move toward the MSB, so the first element of a full load sits in [N*W-1 -: W].
module elem_shift_reg #(
    parameter int N = 10,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           res,
    input  logic           clr,
    input  logic           en,
    input  logic [W-1:0]   din,
    output logic [N*W-1:0] data
);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            data <= '0;
        end else if (clr) begin
            data <= '0;
        end else if (en) begin
            data <= {data[(N-1)*W-1:0], din};
        end
    end

endmodule

// File: rtl/array_packer.sv
// Serial-to-parallel packer that assembles num1 then num2 and presents them as a
// stable pair. Defining ARRAY_PACKER_CHECKSUM_EN adds the chk output (sum of the pair).
module array_packer
    import array_pkg::*;
#(
    parameter int N = ARR_N,
    parameter int W = ARR_W
) (
    input  logic           clk,
    input  logic           res,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    output logic [N*W-1:0] num1,
    output logic [N*W-1:0] num2,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [1:0]     state_dbg
`ifdef ARRAY_PACKER_CHECKSUM_EN
    ,
    output logic [15:0]    chk
`endif
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    // Handshakes: an element transfers on a rising edge where in_valid && in_ready;
    // a pair transfers on a rising edge where out_valid && out_ready. in_data must
    // stay stable while in_valid is high and in_ready is low. flush overrides both.
    state_t          state;
    logic [CW-1:0]   count;
    logic [N*W-1:0]  a_data;
    logic [N*W-1:0]  b_data;
    logic            accept;
    logic            last;
    logic            a_en;
    logic            b_en;

    assign accept    = in_valid && in_ready && !flush;
    assign last      = (count == LAST);
    assign a_en      = accept && (state == FILL_A);
    assign b_en      = accept && (state == FILL_B);
    assign state_dbg = state;

    elem_shift_reg #(.N(N), .W(W)) u_reg_a (
        .clk  (clk),
        .res  (res),
        .clr  (flush),
        .en   (a_en),
        .din  (in_data),
        .data (a_data)
    );

    elem_shift_reg #(.N(N), .W(W)) u_reg_b (
        .clk  (clk),
        .res  (res),
        .clr  (flush),
        .en   (b_en),
        .din  (in_data),
        .data (b_data)
    );

`ifdef ARRAY_PACKER_CHECKSUM_EN
    logic [15:0] acc;
    logic [15:0] acc_next;

    assign acc_next = acc + 16'(in_data);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            acc <= '0;
            chk <= '0;
        end else if (flush) begin
            acc <= '0;
        end else if (accept) begin
            if (state == FILL_B && last) begin
                chk <= acc_next;
                acc <= '0;
            end else begin
                acc <= acc_next;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state     <= FILL_A;
            count     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            num1      <= '0;
            num2      <= '0;
        end else if (flush) begin
            state     <= FILL_A;
            count     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                FILL_A: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        if (last) begin
                            count <= '0;
                            state <= FILL_B;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                FILL_B: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        if (last) begin
                            // B's final shift lands on this same edge, so splice it in here.
                            count     <= '0;
                            state     <= HOLD;
                            num1      <= a_data;
                            num2      <= {b_data[(N-1)*W-1:0], in_data};
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= FILL_A;
                    end else begin
                        in_ready  <= 1'b0;
                    end
                end
                default: begin
                    state     <= FILL_A;
                    count     <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_array_packer.sv
// Directed bench for array_packer: streams hand-built pairs and checks the
// packed outputs, handshakes, flush and asynchronous reset behaviour.
module tb_array_packer;

    logic        clk = 1'b0;
    logic        res;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [79:0] num1;
    logic [79:0] num2;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  state_dbg;
`ifdef ARRAY_PACKER_CHECKSUM_EN
    logic [15:0] chk;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    array_packer dut (
        .clk       (clk),
        .res       (res),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .num1      (num1),
        .num2      (num2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_dbg (state_dbg)
`ifdef ARRAY_PACKER_CHECKSUM_EN
        ,
        .chk       (chk)
`endif
    );

    // Present one element and wait (bounded) until it is accepted; in_valid stays
    // high afterwards unless gap is set, in which case one idle cycle follows.
    task automatic send_elem(input logic [7:0] d, input bit gap);
        bit ok;
        int cyc;
        in_valid = 1'b1;
        in_data  = d;
        cyc = 0;
        do begin
            ok = in_ready;
            @(posedge clk);
            #1;
            cyc++;
        end while (!ok && cyc < 50);
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: element %0h not accepted in %0d cycles", d, cyc);
        end
        if (gap) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        res = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        n_cmp++;
        if (num1 !== 80'h0 || num2 !== 80'h0) begin n_err++; $display("FAIL reset_nums: got %h %h want 0 0", num1, num2); end
        n_cmp++;
        if (state_dbg !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
        res = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_basic_pair();
        for (int i = 1; i <= 10; i++) send_elem(8'(2 * i), 1'b0);
        for (int i = 0; i < 9; i++) send_elem(8'(2 * i + 1), 1'b0);
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid: got %0b want 0", out_valid); end
        send_elem(8'd19, 1'b0);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_out_valid: got %0b want 1", out_valid); end
        n_cmp++;
        if (num1 !== 80'h020406080A0C0E101214) begin n_err++; $display("FAIL basic_num1: got %h want 020406080a0c0e101214", num1); end
        n_cmp++;
        if (num2 !== 80'h01030507090B0D0F1113) begin n_err++; $display("FAIL basic_num2: got %h want 01030507090b0d0f1113", num2); end
        n_cmp++;
        if (in_ready !== 1'b0 || state_dbg !== 2'd2) begin n_err++; $display("FAIL basic_hold: in_ready %0b state %0d want 0 2", in_ready, state_dbg); end
`ifdef ARRAY_PACKER_CHECKSUM_EN
        n_cmp++;
        if (chk !== 16'd210) begin n_err++; $display("FAIL basic_chk: got %0d want 210", chk); end
`endif
    endtask

    task automatic test_hold_stall();
        for (int i = 0; i < 6; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = 8'hFF;
            @(posedge clk);
            #1;
            n_cmp++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || num1 !== 80'h020406080A0C0E101214 || num2 !== 80'h01030507090B0D0F1113) begin
                n_err++;
                $display("FAIL hold_stall: in_ready %0b out_valid %0b num1 %h num2 %h", in_ready, out_valid, num1, num2);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || state_dbg !== 2'd0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL hold_release: out_valid %0b state %0d in_ready %0b want 0 0 1", out_valid, state_dbg, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] first [10];
        first = '{8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
        for (int i = 0; i < 10; i++) send_elem(first[i], 1'b1);
        n_cmp++;
        if (num1 !== 80'h020406080A0C0E101214 || state_dbg !== 2'd1) begin
            n_err++;
            $display("FAIL b2b_mid: num1 %h state %0d want 020406080a0c0e101214 1", num1, state_dbg);
        end
        for (int i = 1; i <= 10; i++) send_elem(8'(i), 1'b0);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || num1 !== 80'h05040302010102030405 || num2 !== 80'h0102030405060708090A) begin
            n_err++;
            $display("FAIL b2b_pair: valid %0b num1 %h num2 %h want 1 05040302010102030405 0102030405060708090a", out_valid, num1, num2);
        end
`ifdef ARRAY_PACKER_CHECKSUM_EN
        n_cmp++;
        if (chk !== 16'd85) begin n_err++; $display("FAIL b2b_chk: got %0d want 85", chk); end
`endif
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_flush_fill();
        for (int i = 0; i < 10; i++) send_elem(8'(8'h10 + i), 1'b0);
        for (int i = 0; i < 7; i++) send_elem(8'(8'h20 + i), 1'b0);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if (state_dbg !== 2'd0 || out_valid !== 1'b0 || num1 !== 80'h05040302010102030405) begin
            n_err++;
            $display("FAIL flush_fill_state: state %0d valid %0b num1 %h", state_dbg, out_valid, num1);
        end
        for (int i = 0; i < 10; i++) send_elem(8'(8'h31 + i), 1'b0);
        for (int i = 0; i < 9; i++) send_elem(8'(8'h41 + i), 1'b0);
        n_cmp++;
        if (out_valid !== 1'b0 || num2 !== 80'h0102030405060708090A) begin
            n_err++;
            $display("FAIL flush_fill_early: valid %0b num2 %h", out_valid, num2);
        end
        send_elem(8'h4A, 1'b0);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || num1 !== 80'h3132333435363738393A || num2 !== 80'h4142434445464748494A) begin
            n_err++;
            $display("FAIL flush_fill_pair: valid %0b num1 %h num2 %h want 1 3132333435363738393a 4142434445464748494a", out_valid, num1, num2);
        end
`ifdef ARRAY_PACKER_CHECKSUM_EN
        n_cmp++;
        if (chk !== 16'd1230) begin n_err++; $display("FAIL flush_fill_chk: got %0d want 1230", chk); end
`endif
    endtask

    task automatic test_flush_hold();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || state_dbg !== 2'd0) begin
            n_err++;
            $display("FAIL flush_hold_ctrl: valid %0b in_ready %0b state %0d want 0 1 0", out_valid, in_ready, state_dbg);
        end
        n_cmp++;
        if (num1 !== 80'h3132333435363738393A || num2 !== 80'h4142434445464748494A) begin
            n_err++;
            $display("FAIL flush_hold_nums: num1 %h num2 %h", num1, num2);
        end
        out_ready = 1'b1;
        idle(2);
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || state_dbg !== 2'd0) begin
            n_err++;
            $display("FAIL stray_out_ready: valid %0b state %0d want 0 0", out_valid, state_dbg);
        end
    endtask

    task automatic test_reset_mid_load();
        for (int i = 0; i < 10; i++) send_elem(8'(8'h50 + i), 1'b0);
        for (int i = 0; i < 3; i++) send_elem(8'(8'h60 + i), 1'b0);
        in_valid = 1'b0;
        res = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || num1 !== 80'h0 || num2 !== 80'h0 || state_dbg !== 2'd0) begin
            n_err++;
            $display("FAIL async_reset: valid %0b in_ready %0b num1 %h num2 %h state %0d", out_valid, in_ready, num1, num2, state_dbg);
        end
        @(posedge clk);
        #1;
        res = 1'b1;
        for (int i = 0; i < 10; i++) send_elem(8'(8'hA0 + i), 1'b0);
        for (int i = 0; i < 9; i++) send_elem(8'(8'hB0 + i), 1'b0);
        n_cmp++;
        if (out_valid !== 1'b0 || num1 !== 80'h0) begin
            n_err++;
            $display("FAIL reset_reload_early: valid %0b num1 %h want 0 0", out_valid, num1);
        end
        send_elem(8'hB9, 1'b0);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || num1 !== 80'hA0A1A2A3A4A5A6A7A8A9 || num2 !== 80'hB0B1B2B3B4B5B6B7B8B9) begin
            n_err++;
            $display("FAIL reset_reload_pair: valid %0b num1 %h num2 %h", out_valid, num1, num2);
        end
`ifdef ARRAY_PACKER_CHECKSUM_EN
        n_cmp++;
        if (chk !== 16'd3450) begin n_err++; $display("FAIL reset_reload_chk: got %0d want 3450", chk); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic_pair();
        test_hold_stall();
        test_back_to_back();
        test_flush_fill();
        test_flush_hold();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/array_packer.md
Name: array_packer

Overview:
- Upstream feeder for the array summation stage.
- Accepts a serial stream of 8-bit elements over a valid/ready handshake and assembles two packed arrays, num1 then num2, each holding N elements.
- Presents both arrays, double-buffered, with an out_valid/out_ready handshake so the summation stage always sees stable operands.

Parameters:
- N, 10, elements per array
- W, 8, element width in bits

Ports:
- clk  in  1  system clock; all state updates on rising edge
- res  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous abort of a partial load
- in_valid  in  1  in_data holds an element
- in_ready  out  1  packer can accept an element
- in_data  in  W  element value
- num1  out  N*W  packed array A; first element accepted in bits [N*W-1 -: W]
- num2  out  N*W  packed array B; same ordering
- out_valid  out  1  num1/num2 hold a complete, unconsumed pair
- out_ready  in  1  consumer takes the pair

Behaviour:
- Reset (res=0, asynchronous):
  - state=FILL_A, element count=0
  - in_ready=0 while res is low
  - out_valid=0
  - num1, num2 and the assembly registers all 0
- States:
  - FILL_A: in_ready=1. Each accepted element (in_valid & in_ready) shifts into assembly reg A from the LSB end, moving earlier elements toward the MSB. Count increments. On the N-th accept: count←0, go to FILL_B.
  - FILL_B: same as FILL_A, into assembly reg B. On the N-th accept: copy A→num1 and B→num2 on that edge, set out_valid=1, go to HOLD.
  - HOLD: in_ready=0, out_valid=1.
    - out_valid & out_ready → out_valid=0 on the next edge, go to FILL_A.
    - num1/num2 keep their values until the next completed pair.
- Latency: out_valid rises on the clock edge that accepts the 2N-th element, i.e. it is visible the cycle after that accept.
- Throughput: one element per cycle, plus one HOLD cycle minimum per pair.
- num1/num2 change only on the FILL_B→HOLD transition; never mid-load.
- flush=1:
  - Next edge: count←0, assembly regs←0, state←FILL_A.
  - An element presented in the same cycle is dropped. Flush wins over the handshake.
  - In HOLD, flush also clears out_valid. num1/num2 retain their values.
- Boundary rules:
  - in_valid with in_ready=0 is ignored, with no side effects.
  - The upstream source must hold in_data while in_valid=1 and in_ready=0.
  - Count runs 0..N-1 only; there is no wrap beyond N.
  - out_ready while out_valid=0 has no effect.
- Reset mid-load discards all partial data. No output toggles after res rises until new data completes.

Optional Feature:
- ARRAY_PACKER_CHECKSUM_EN defined:
  - Adds output port chk[15:0]: the sum of all 2N elements of the published pair, modulo 2^16.
  - Accumulated during the fill states and published alongside num1/num2 on the same edge.
  - Reset to 0. A flush clears the running accumulator but not the published chk.
- Undefined: no chk port and no accumulator logic.

Decomposition:
- Package array_pkg:
  - ARR_N=10, ARR_W=8
  - state typedef enum {FILL_A, FILL_B, HOLD}
  - count width localparam $clog2(N)
- One natural sub-module: elem_shift_reg.
  - Parameterised by N and W.
  - Shift-in-at-LSB register with enable and clear.
  - Instantiated twice, for A and B.

Test Plan:
- Reset, then stream 2,4,6,...,20 then 1,3,...,19 with in_valid held high → out_valid=1 on the cycle after the 20th accept. num1 = 0x020406080A0C0E101214, num2 = 0x01030507090B0D0F1113, chk=210 when enabled.
- Stream with in_valid toggling every other cycle and out_ready=0 → in_ready=0 in HOLD, extra elements ignored, num1/num2 stable. Raise out_ready → out_valid falls next edge and state returns to FILL_A.
- Two back-to-back pairs (second: 5,4,3,2,1,1,2,3,4,5 / 1..10) → num1 holds the first pair until the second completes, then becomes 0x05040302010102030405, num2 0x0102030405060708090A, chk=85.
- Flush after 7 elements of num2, asserted together with in_valid → that element dropped, next 20 elements form a clean pair, previous num1/num2 unchanged until then.
- Drive res low mid-FILL_B → asynchronously out_valid=0, num1=num2=0, in_ready=0. After res releases, a full 20-element load is needed before out_valid.
- Flush during HOLD → out_valid=0 next edge, num1/num2 retain their values, in_ready=1.
